// File: rtl/agu_mem_pipe.sv
// agu_mem_pipe
//   Address generation and data-cache access unit of the memory pipeline.
//   Each cycle it may accept one issued load or store micro-op and compute
//   its effective address op1 + imm. Accepted ops wait in an in-order queue.
//   The op at the head of the queue drives a single-port data cache, which
//   reads asynchronously and writes on the clock edge. Stores do a
//   read-modify-write merge of the cache word. Loads select and extend their
//   bytes and write back {o_val, o_addr, o_data} one edge later.
//
// Optional feature macro: AGU_MISALIGN_CHECK_EN
//   When defined, a misaligned halfword or word access is dropped at the head.
//   The new port o_misalign pulses in the slot where o_val would have been.
//
// Ports
//   i_clk, i_rst    : clock (rising edge) and synchronous active-high reset
//   i_instr         : packed {val, func, brmask, uop, imm, rd, op2, op1}
//   i_brkill        : branch kill mask; kills matching queued and incoming ops
//   o_full          : queue full, so upstream must hold memory ops
//   o_val/o_addr/o_data : load writeback (valid, destination register, data)
//   o_misalign      : misaligned access dropped (only with the macro above)
//   dcache_i_*      : cache word address, write data, write enable, kill
//   dcache_o_data   : cache read data, combinational from dcache_i_addr
//   dcache_o_nack   : cache cannot serve this cycle, so the head retries
module agu_mem_pipe #(
  parameter  int WIDTH_REG = 7,
  parameter  int WIDTH_BRM = 4,
  parameter  int WIDTH_TAG = 4,
  parameter  int WIDTH_MEM = 4,
  localparam int WIDTH     = 2 + 10 + WIDTH_BRM + 7 + 32 + WIDTH_REG + 64
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [WIDTH-1:0]     i_instr,
  input  logic [WIDTH_BRM-1:0] i_brkill,
  output logic                 o_full,
  output logic [31:0]          o_data,
  output logic [WIDTH_REG-1:0] o_addr,
  output logic                 o_val,
`ifdef AGU_MISALIGN_CHECK_EN
  output logic                 o_misalign,
`endif
  output logic [WIDTH_MEM-1:0] dcache_i_addr,
  output logic [31:0]          dcache_i_data,
  output logic                 dcache_i_we,
  output logic                 dcache_i_kill,
  input  logic [31:0]          dcache_o_data,
  input  logic                 dcache_o_nack
);

  localparam int         DEPTH     = 2 ** WIDTH_TAG;
  localparam logic [6:0] UOP_LOAD  = 7'b0000011;
  localparam logic [6:0] UOP_STORE = 7'b0100011;

  typedef struct packed {
    logic [1:0]           val;
    logic [9:0]           func;
    logic [WIDTH_BRM-1:0] brmask;
    logic [6:0]           uop;
    logic [31:0]          imm;
    logic [WIDTH_REG-1:0] rd;
    logic [31:0]          op2;
    logic [31:0]          op1;
  } instr_t;

  typedef struct packed {
    logic                 is_store;
    logic [2:0]           funct3;
    logic [1:0]           off;
    logic [WIDTH_MEM-1:0] waddr;
    logic [31:0]          op2;
    logic [WIDTH_REG-1:0] rd;
    logic [WIDTH_BRM-1:0] brmask;
  } entry_t;

  instr_t ins;
  logic [31:0] ea;
  logic        accept;
  entry_t      new_entry;

  assign ins    = i_instr;
  assign ea     = ins.op1 + ins.imm;
  assign accept = ins.val[0] && (ins.uop == UOP_LOAD || ins.uop == UOP_STORE) &&
                  ((ins.brmask & i_brkill) == '0) && !o_full;

  assign new_entry = '{is_store: (ins.uop == UOP_STORE), funct3: ins.func[2:0],
                       off: ea[1:0], waddr: ea[WIDTH_MEM+1:2], op2: ins.op2,
                       rd: ins.rd, brmask: ins.brmask};

  // Instruction bits that this unit never looks at.
  logic unused_bits;
  assign unused_bits = ^{ins.val[1], ins.func[9:3], ea[31:WIDTH_MEM+2]};

  // ---------------------------------------------------------------- queue
  entry_t               q_mem [DEPTH];
  logic [DEPTH-1:0]     vld_q;
  logic [WIDTH_TAG-1:0] head_q, tail_q;
  logic [WIDTH_TAG:0]   count_q;

  entry_t head;
  logic   empty, head_dead, misalign, do_access, pop, load_done;

  assign head   = q_mem[head_q];
  assign empty  = (count_q == '0);
  assign o_full = (count_q == (WIDTH_TAG + 1)'(DEPTH));

  // The head is dead if it was killed earlier or is killed this cycle.
  // A dead head leaves without touching the cache, even under nack.
  assign head_dead = !vld_q[head_q] || ((head.brmask & i_brkill) != '0);

`ifdef AGU_MISALIGN_CHECK_EN
  // funct3[1:0] is the size: 0 byte, 1 half, anything else a full word.
  assign misalign = ((head.funct3[1:0] == 2'd1) && head.off[0]) ||
                    (head.funct3[1] && (head.off != 2'd0)) ||
                    ((head.funct3[1:0] == 2'd3) && (head.off != 2'd0));
`else
  assign misalign = 1'b0;
`endif

  assign do_access = !empty && !head_dead && !misalign;
  assign pop       = !empty && (head_dead || !dcache_o_nack);
  assign load_done = do_access && !head.is_store && !dcache_o_nack;

  assign dcache_i_addr = head.waddr;
  assign dcache_i_we   = do_access && head.is_store;
  assign dcache_i_kill = !empty && head_dead;

  // ------------------------------------------------ store merge / load select
  logic [31:0] wdata, rdata;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  // NOTE: every always_comb target gets a default first so no latch is inferred.
  always_comb begin
    wdata = dcache_o_data;
    unique case (head.funct3[1:0])
      2'd0:    wdata[{head.off, 3'b000} +: 8]     = head.op2[7:0];
      2'd1:    wdata[{head.off[1], 4'b0000} +: 16] = head.op2[15:0];
      default: wdata = head.op2;
    endcase
  end
  assign dcache_i_data = wdata;

  assign rbyte = dcache_o_data[{head.off, 3'b000} +: 8];
  assign rhalf = dcache_o_data[{head.off[1], 4'b0000} +: 16];

  always_comb begin
    rdata = dcache_o_data;
    case (head.funct3)
      3'd0:    rdata = {{24{rbyte[7]}}, rbyte};
      3'd1:    rdata = {{16{rhalf[15]}}, rhalf};
      3'd4:    rdata = {24'd0, rbyte};
      3'd5:    rdata = {16'd0, rhalf};
      default: rdata = dcache_o_data;
    endcase
  end

  // ------------------------------------------------------ sequential state
  logic                 val_q;
  logic [31:0]          data_q;
  logic [WIDTH_REG-1:0] addr_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its pre-edge inputs, whatever order the blocks run in.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      val_q   <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
    end else begin
      if (accept) tail_q <= tail_q + 1'b1;
      if (pop)    head_q <= head_q + 1'b1;
      count_q <= count_q + {{WIDTH_TAG{1'b0}}, accept} - {{WIDTH_TAG{1'b0}}, pop};
      val_q   <= load_done;
      if (load_done) begin
        data_q <= rdata;
        addr_q <= head.rd;
      end
    end
  end

  // NOTE: queue storage is left unreset. Only the pointers and count define
  // which slots are live, so the contents need no reset.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if ((q_mem[i].brmask & i_brkill) != '0) vld_q[i] <= 1'b0;
    end
    if (accept) begin
      q_mem[tail_q] <= new_entry;
      vld_q[tail_q] <= 1'b1;
    end
  end

  assign o_val  = val_q;
  assign o_data = data_q;
  assign o_addr = addr_q;

`ifdef AGU_MISALIGN_CHECK_EN
  logic misalign_q;
  always_ff @(posedge i_clk) begin
    if (i_rst) misalign_q <= 1'b0;
    else       misalign_q <= !empty && !head_dead && misalign && !dcache_o_nack;
  end
  assign o_misalign = misalign_q;
`endif

endmodule

// File: tb/tb_agu_mem_pipe.sv
// tb_agu_mem_pipe
//   Bench for agu_mem_pipe. It has a behavioural data cache and a reference
//   model. The model keeps memory as a byte array and the queue as a SV queue
//   of decoded ops. Each cycle, on the falling edge, it checks the cache
//   request and the writeback outputs against the model, then advances it.
module tb_agu_mem_pipe;

  localparam int WR = 7, WB = 4, WM = 4, DEPTH = 16;
  localparam int W  = 2 + 10 + WB + 7 + 32 + WR + 64;
  localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011, BR = 7'b1100011;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic [W-1:0]  i_instr = '0;
  logic [WB-1:0] i_brkill = '0;
  logic          o_full, o_val, dcache_i_we, dcache_i_kill, dcache_o_nack = 1'b0;
  logic [31:0]   o_data, dcache_i_data, dcache_o_data;
  logic [WR-1:0] o_addr;
  logic [WM-1:0] dcache_i_addr;

  always #5 i_clk = ~i_clk;

  agu_mem_pipe dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_instr(i_instr), .i_brkill(i_brkill),
    .o_full(o_full), .o_data(o_data), .o_addr(o_addr), .o_val(o_val),
    .dcache_i_addr(dcache_i_addr), .dcache_i_data(dcache_i_data),
    .dcache_i_we(dcache_i_we), .dcache_i_kill(dcache_i_kill),
    .dcache_o_data(dcache_o_data), .dcache_o_nack(dcache_o_nack)
  );

  // Behavioural cache: asynchronous read; the write is applied by the bench
  // just after each rising edge.
  logic [31:0] cache [16];
  assign dcache_o_data = cache[dcache_i_addr];

  typedef struct packed {
    logic [1:0]  val;
    logic [9:0]  func;
    logic [3:0]  bm;
    logic [6:0]  uop;
    logic [31:0] imm;
    logic [6:0]  rd;
    logic [31:0] op2;
    logic [31:0] op1;
  } stim_t;

  typedef struct {
    bit          st;
    bit [2:0]    f3;
    bit [31:0]   ea;
    bit [31:0]   op2;
    bit [6:0]    rd;
    bit [3:0]    bm;
    bit          dead;
  } op_t;

  // Reference model state.
  op_t         q[$];
  logic [7:0]  ref_mem [64];
  logic        exp_val  = 1'b0;
  logic [31:0] exp_data = '0;
  logic [6:0]  exp_addr = '0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic stim_t mk(input logic [6:0] uop, input logic [2:0] f3,
                               input logic [31:0] op1, input logic [31:0] imm,
                               input logic [31:0] op2, input logic [6:0] rd,
                               input logic [3:0] bm);
    stim_t s;
    s.val = 2'b01; s.func = {7'd0, f3}; s.bm = bm; s.uop = uop;
    s.imm = imm; s.rd = rd; s.op2 = op2; s.op1 = op1;
    return s;
  endfunction

  function automatic logic [31:0] ref_word(input int w);
    return {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
  endfunction

  // Load result from byte memory: pick the bytes, then extend.
  function automatic logic [31:0] load_value(input op_t o);
    int a  = int'(o.ea[5:0]);
    int hb = a - (a % 2);
    int wb = a - (a % 4);
    case (o.f3)
      3'd0:    return {{24{ref_mem[a][7]}}, ref_mem[a]};
      3'd4:    return {24'd0, ref_mem[a]};
      3'd1:    return {{16{ref_mem[hb+1][7]}}, ref_mem[hb+1], ref_mem[hb]};
      3'd5:    return {16'd0, ref_mem[hb+1], ref_mem[hb]};
      default: return {ref_mem[wb+3], ref_mem[wb+2], ref_mem[wb+1], ref_mem[wb]};
    endcase
  endfunction

  // Word held in memory after the store takes effect.
  function automatic logic [31:0] merged(input op_t o);
    logic [7:0] b [4];
    int w = int'(o.ea[5:2]);
    int k = int'(o.ea[1:0]);
    int h = 2 * int'(o.ea[1]);
    for (int i = 0; i < 4; i++) b[i] = ref_mem[4*w+i];
    case (o.f3)
      3'd0: b[k] = o.op2[7:0];
      3'd1: begin b[h] = o.op2[7:0]; b[h+1] = o.op2[15:8]; end
      default: for (int i = 0; i < 4; i++) b[i] = o.op2[8*i +: 8];
    endcase
    return {b[3], b[2], b[1], b[0]};
  endfunction

  // One clock cycle: drive, check on the falling edge, advance the model,
  // then apply any cache write just after the rising edge.
  task automatic cycle(input stim_t s, input logic [3:0] kill, input logic nack,
                       input logic rst);
    op_t h;
    bit has, dead, full_pre, nv, wr;
    logic [3:0]  wa;
    logic [31:0] wd, mw;
    i_instr = s; i_brkill = kill; dcache_o_nack = nack; i_rst = rst;
    @(negedge i_clk);
    full_pre = (q.size() == DEPTH);
    check("full", 32'(o_full), 32'(full_pre));
    check("o_val", 32'(o_val), 32'(exp_val));
    check("o_data", o_data, exp_data);
    check("o_addr", 32'(o_addr), 32'(exp_addr));
    has = (q.size() != 0);
    dead = 1'b0;
    if (has) begin
      h = q[0];
      dead = h.dead || ((h.bm & kill) != 0);
      check("kill", 32'(dcache_i_kill), 32'(dead));
      if (!dead) begin
        check("waddr", 32'(dcache_i_addr), 32'(h.ea[5:2]));
        check("we", 32'(dcache_i_we), 32'(h.st));
        if (h.st) check("wdata", dcache_i_data, merged(h));
      end else begin
        check("we_dead", 32'(dcache_i_we), 32'd0);
      end
    end else begin
      check("we_idle", 32'(dcache_i_we), 32'd0);
      check("kill_idle", 32'(dcache_i_kill), 32'd0);
    end
    wr = dcache_i_we && !dcache_i_kill && !nack;
    wa = dcache_i_addr;
    wd = dcache_i_data;

    nv = 1'b0;
    if (has && (dead || !nack)) begin
      if (!dead) begin
        if (h.st) begin
          mw = merged(h);
          for (int i = 0; i < 4; i++) ref_mem[4*int'(h.ea[5:2])+i] = mw[8*i +: 8];
        end else begin
          nv = 1'b1;
          exp_data = load_value(h);
          exp_addr = h.rd;
        end
      end
      void'(q.pop_front());
    end
    exp_val = nv;
    for (int i = 0; i < q.size(); i++) begin
      op_t t = q[i];
      if ((t.bm & kill) != 0) begin t.dead = 1'b1; q[i] = t; end
    end
    if (s.val[0] && (s.uop == LD || s.uop == ST) && ((s.bm & kill) == 0) && !full_pre) begin
      op_t n;
      n.st = (s.uop == ST); n.f3 = s.func[2:0]; n.ea = s.op1 + s.imm;
      n.op2 = s.op2; n.rd = s.rd; n.bm = s.bm; n.dead = 1'b0;
      q.push_back(n);
    end
    if (rst) begin
      q.delete();
      exp_val = 1'b0; exp_data = '0; exp_addr = '0;
    end
    @(posedge i_clk);
    #1;
    if (wr) cache[wa] = wd;
  endtask

  task automatic idle(input int n, input logic nack);
    for (int i = 0; i < n; i++) cycle('0, 4'd0, nack, 1'b0);
  endtask

  initial begin
    stim_t s;
    logic [31:0] w;
    // Power-up reset before the model starts tracking.
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    for (int i = 0; i < 16; i++) begin
      w = (i == 1) ? 32'h8000_00F0 : $urandom;
      cache[i] = w;
      for (int k = 0; k < 4; k++) ref_mem[4*i+k] = w[8*k +: 8];
    end
    cycle('0, 4'd0, 1'b0, 1'b1);             // reset values
    idle(1, 1'b0);

    // LW from word 1 via ea = 2 + 2.
    cycle(mk(LD, 3'd2, 32'd2, 32'd2, 32'd0, 7'd5, 4'd0), 4'd0, 1'b0, 1'b0);
    idle(1, 1'b0);
    check("lw_latency_val", 32'(o_val), 32'd1);
    check("lw_word1", o_data, 32'h8000_00F0);
    idle(1, 1'b0);

    // SB 0x5A to ea 5, then LBU and LB from the same byte.
    cycle(mk(ST, 3'd0, 32'd1, 32'd4, 32'hFFFF_FF5A, 7'd0, 4'd0), 4'd0, 1'b0, 1'b0);
    cycle(mk(LD, 3'd4, 32'd5, 32'd0, 32'd0, 7'd6, 4'd0), 4'd0, 1'b0, 1'b0);
    cycle(mk(LD, 3'd0, 32'd0, 32'd5, 32'd0, 7'd7, 4'd0), 4'd0, 1'b0, 1'b0);
    idle(3, 1'b0);
    check("sb_word1", cache[1], 32'h8000_5AF0);

    // Branch uop is ignored.
    cycle(mk(BR, 3'd0, 32'd0, 32'd0, 32'd0, 7'd9, 4'd2), 4'd0, 1'b0, 1'b0);
    idle(2, 1'b0);

    // Head load killed; the next load completes.
    cycle(mk(LD, 3'd2, 32'd8, 32'd0, 32'd0, 7'd10, 4'h2), 4'd0, 1'b0, 1'b0);
    cycle(mk(LD, 3'd2, 32'd12, 32'd0, 32'd0, 7'd11, 4'h0), 4'h2, 1'b0, 1'b0);
    idle(3, 1'b0);

    // Store held by nack for three cycles.
    cycle(mk(ST, 3'd2, 32'd8, 32'd0, 32'hDEAD_BEEF, 7'd0, 4'd0), 4'd0, 1'b1, 1'b0);
    idle(3, 1'b1);
    idle(2, 1'b0);
    check("nack_store", cache[2], 32'hDEAD_BEEF);

    // Fill the queue under nack, try to overflow, then pop while full.
    for (int i = 0; i < DEPTH; i++)
      cycle(mk(ST, 3'd2, 32'(4*i), 32'd0, 32'(i) * 32'h0101_0101, 7'd0, 4'd0), 4'd0, 1'b1, 1'b0);
    check("full_flag", 32'(o_full), 32'd1);
    cycle(mk(ST, 3'd2, 32'd0, 32'd0, 32'h1234_5678, 7'd0, 4'd0), 4'd0, 1'b1, 1'b0);
    cycle(mk(ST, 3'd2, 32'd4, 32'd0, 32'h8765_4321, 7'd0, 4'd0), 4'd0, 1'b0, 1'b0);
    idle(DEPTH + 2, 1'b0);

    // Reset with ops pending flushes the queue.
    for (int i = 0; i < 3; i++)
      cycle(mk(LD, 3'd2, 32'(4*i), 32'd0, 32'd0, 7'(20+i), 4'd0), 4'd0, 1'b1, 1'b0);
    cycle('0, 4'd0, 1'b1, 1'b1);
    idle(3, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 500; n++) begin
      int r = int'($urandom_range(99));
      s.val  = {1'($urandom), 1'($urandom_range(99) < 90)};
      s.func = {7'($urandom), 3'($urandom)};
      s.uop  = (r < 45) ? LD : (r < 85) ? ST : (r < 93) ? BR : 7'($urandom);
      if (s.uop == ST) s.func[2:0] = 3'($urandom_range(2));
      s.bm   = ($urandom_range(1) == 0) ? 4'd0 : 4'($urandom);
      s.imm  = $urandom; s.op1 = $urandom; s.op2 = $urandom; s.rd = 7'($urandom);
      cycle(s, ($urandom_range(7) == 0) ? 4'($urandom) : 4'd0,
            $urandom_range(3) == 0, 1'b0);
    end
    idle(DEPTH + 4, 1'b0);

    for (int i = 0; i < 16; i++) check("mem_final", cache[i], ref_word(i));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
